// File: rtl/nco_ctrl_pkg.sv
// Shared NCO control definitions: sequencer states and default datapath widths.
// Also used by the top-level NCO and DSM blocks so their widths stay in step.
package nco_ctrl_pkg;

   localparam int ACC_WIDTH = 32;
   localparam int SEL_WIDTH = 4;
   localparam int REF_STEP  = 859000;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      MULT = 2'd2,
      RAMP = 2'd3
   } state_t;

endpackage

// File: rtl/step_shift_add_mult.sv
// Serial LSB-first shift-add multiplier, B_WIDTH cycles per product, modulo 2^A_WIDTH.
// Operands are captured on start; done pulses in the last cycle together with a valid product.
module step_shift_add_mult #(
   parameter int A_WIDTH = nco_ctrl_pkg::ACC_WIDTH,
   parameter int B_WIDTH = nco_ctrl_pkg::SEL_WIDTH
) (
   input  logic               aclk,
   input  logic               arst_n,
   input  logic               start,
   input  logic [A_WIDTH-1:0] a,
   input  logic [B_WIDTH-1:0] b,
   output logic               done,
   output logic [A_WIDTH-1:0] product
);
   localparam int CW = $clog2(B_WIDTH + 1);

   logic [A_WIDTH-1:0] a_q;
   logic [A_WIDTH-1:0] acc_q;
   logic [A_WIDTH-1:0] acc_nxt;
   logic [B_WIDTH-1:0] b_q;
   logic [CW-1:0]      cnt_q;
   logic               run_q;

   always_comb begin
      acc_nxt = acc_q;
      if (b_q[0]) acc_nxt = acc_q + a_q;
   end

   // product is taken combinationally so the final partial sum lands in the done cycle
   assign done    = run_q && (cnt_q == CW'(1));
   assign product = acc_nxt;

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         a_q   <= a;
         b_q   <= b;
         acc_q <= '0;
         cnt_q <= CW'(B_WIDTH);
         run_q <= 1'b1;
      end else if (run_q) begin
         acc_q <= acc_nxt;
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         cnt_q <= cnt_q - CW'(1);
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/nco_step_scheduler.sv
// NCO phase-step scheduler: frequency code -> target step, then a rate-limited ramp of the
// live step toward it, delivered to the NCO as single AXI-stream beats.
//
// state | meaning
// INIT  | emit one beat of step 0 after reset, wait for its handshake
// IDLE  | live step settled; start a multiply when a request is pending
// MULT  | serial REF_STEP*sel in progress; target latched (or muted to 0) at exit
// RAMP  | tick-paced bounded steps toward target; exit once settled and beat accepted
module nco_step_scheduler #(
   parameter int ACC_WIDTH = nco_ctrl_pkg::ACC_WIDTH,
   parameter int SEL_WIDTH = nco_ctrl_pkg::SEL_WIDTH,
   parameter int REF_STEP  = nco_ctrl_pkg::REF_STEP,
   parameter int RAMP_INC  = 214750,
   parameter int TICK_DIV  = 1000
) (
   input  logic                 aclk,
   input  logic                 arst_n,
   input  logic [SEL_WIDTH-1:0] sel_in,
   input  logic                 sel_valid,
   input  logic                 mute,
   output logic [ACC_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 busy,
   output logic                 at_target
);
   import nco_ctrl_pkg::*;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [ACC_WIDTH-1:0] REF_STEP_V = ACC_WIDTH'(REF_STEP);
   localparam logic [ACC_WIDTH-1:0] RAMP_INC_V = ACC_WIDTH'(RAMP_INC);
   localparam logic [TW-1:0]        TICK_LOAD  = TW'(TICK_DIV - 1);

   state_t               state_q;
   state_t               state_nxt;
   logic [ACC_WIDTH-1:0] step_q;
   logic [ACC_WIDTH-1:0] target_q;
   logic [ACC_WIDTH-1:0] step_nxt;
   logic [ACC_WIDTH:0]   diff;
   logic [ACC_WIDTH-1:0] mag;
   logic [ACC_WIDTH-1:0] delta;
   logic                 dir_up;
   logic                 pend_valid_q;
   logic [SEL_WIDTH-1:0] pend_sel_q;
   logic [SEL_WIDTH-1:0] last_sel_q;
   logic                 mute_q;
   logic [TW-1:0]        tick_q;
   logic                 tick_zero;
   logic                 stall;
   logic                 mult_start;
   logic                 mult_done;
   logic [ACC_WIDTH-1:0] mult_product;
   logic                 mult_exit;
   logic                 init_issue;
   logic                 ramp_tick;
   logic                 ramp_update;

   assign stall     = m_axis_tvalid && !m_axis_tready;
   assign tick_zero = (tick_q == '0);
   assign mult_exit = (state_q == MULT) && mult_done;

   // direction comes from the borrow of a one-bit-wider difference; never overshoots target
   always_comb begin
      diff     = {1'b0, target_q} - {1'b0, step_q};
      dir_up   = !diff[ACC_WIDTH];
      mag      = dir_up ? diff[ACC_WIDTH-1:0] : (step_q - target_q);
      delta    = (mag > RAMP_INC_V) ? RAMP_INC_V : mag;
      step_nxt = dir_up ? (step_q + delta) : (step_q - delta);
   end

   step_shift_add_mult #(
      .A_WIDTH (ACC_WIDTH),
      .B_WIDTH (SEL_WIDTH)
   ) u_mult (
      .aclk    (aclk),
      .arst_n  (arst_n),
      .start   (mult_start),
      .a       (REF_STEP_V),
      .b       (pend_sel_q),
      .done    (mult_done),
      .product (mult_product)
   );

   always_ff @(posedge aclk) begin
      if (!arst_n) state_q <= INIT;
      else         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         INIT: if (m_axis_tvalid && m_axis_tready) state_nxt = IDLE;
         IDLE: if (pend_valid_q) state_nxt = MULT;
         MULT: if (mult_done) state_nxt = RAMP;
         RAMP: if ((step_q == target_q) &&
                   (m_axis_tvalid ? m_axis_tready : tick_zero)) state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      at_target   = 1'b0;
      mult_start  = 1'b0;
      init_issue  = 1'b0;
      ramp_tick   = 1'b0;
      ramp_update = 1'b0;
      case (state_q)
         INIT: init_issue = !m_axis_tvalid;
         IDLE: begin
            at_target  = !m_axis_tvalid;
            mult_start = pend_valid_q;
         end
         MULT: busy = 1'b1;
         RAMP: begin
            busy        = 1'b1;
            ramp_tick   = !stall;
            ramp_update = !stall && tick_zero && (step_q != target_q);
         end
         default: ;
      endcase
   end

   // a new strobe or mute edge always wins over consumption, so it stays pending
   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         pend_valid_q <= 1'b0;
         pend_sel_q   <= '0;
         last_sel_q   <= '0;
         mute_q       <= 1'b0;
      end else begin
         mute_q <= mute;
         if (sel_valid) begin
            pend_valid_q <= 1'b1;
            pend_sel_q   <= sel_in;
            last_sel_q   <= sel_in;
         end else if (mute != mute_q) begin
            pend_valid_q <= 1'b1;
            pend_sel_q   <= last_sel_q;
         end else if (mult_start) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!arst_n)        tick_q <= TICK_LOAD;
      else if (mult_exit) tick_q <= TICK_LOAD;
      else if (ramp_tick) tick_q <= tick_zero ? TICK_LOAD : (tick_q - TW'(1));
   end

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         step_q   <= '0;
         target_q <= '0;
      end else begin
         if (mult_exit)   target_q <= mute ? '0 : mult_product;
         if (ramp_update) step_q   <= step_nxt;
      end
   end

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
      end else if (init_issue) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= '0;
      end else if (ramp_update) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= step_nxt;
      end else if (m_axis_tvalid && m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nco_step_scheduler.sv
// Directed bench for nco_step_scheduler with TICK_DIV=4: records every accepted beat and
// compares it with hand values and a small ramp model.
module tb_nco_step_scheduler;

   localparam int          ACC_W = 32;
   localparam logic [31:0] INC   = 32'd214750;
   localparam logic [31:0] REF   = 32'd859000;

   logic             aclk = 1'b0;
   logic             arst_n;
   logic [3:0]       sel_in;
   logic             sel_valid;
   logic             mute;
   logic [ACC_W-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic             busy;
   logic             at_target;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   logic [31:0] beats[$];
   int          beat_cyc[$];
   logic [31:0] exp_q[$];

   nco_step_scheduler #(
      .ACC_WIDTH (32),
      .SEL_WIDTH (4),
      .REF_STEP  (859000),
      .RAMP_INC  (214750),
      .TICK_DIV  (4)
   ) dut (
      .aclk          (aclk),
      .arst_n        (arst_n),
      .sel_in        (sel_in),
      .sel_valid     (sel_valid),
      .mute          (mute),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .at_target     (at_target)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (arst_n && m_axis_tvalid && m_axis_tready) begin
         beats.push_back(m_axis_tdata);
         beat_cyc.push_back(cyc);
      end
      cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic strobe(input logic [3:0] s);
      sel_in    = s;
      sel_valid = 1'b1;
      @(negedge aclk);
      sel_valid = 1'b0;
   endtask

   task automatic clear_log();
      beats.delete();
      beat_cyc.delete();
      exp_q.delete();
   endtask

   // settled means idle for several consecutive cycles, so a one-cycle IDLE between ramps is skipped
   task automatic wait_idle(input int budget);
      int run = 0;
      for (int i = 0; i < budget && run < 3; i++) begin
         @(negedge aclk);
         run = (at_target && !busy) ? run + 1 : 0;
      end
      chk("settle_at_target", 64'(at_target), 64'd1);
      chk("settle_busy", 64'(busy), 64'd0);
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int i = 0; i < budget && beats.size() < n; i++) @(negedge aclk);
      chk("beat_count_reached", 64'(beats.size() >= n), 64'd1);
   endtask

   task automatic model_ramp(input logic [31:0] from, input logic [31:0] to);
      logic [31:0] s;
      s = from;
      while (s != to) begin
         if (to > s) s = ((to - s) > INC) ? s + INC : to;
         else        s = ((s - to) > INC) ? s - INC : to;
         exp_q.push_back(s);
      end
   endtask

   task automatic compare_seq(input string tag);
      chk({tag, "_count"}, 64'(beats.size()), 64'(exp_q.size()));
      for (int i = 0; i < beats.size() && i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), 64'(beats[i]), 64'(exp_q[i]));
   endtask

   initial begin
      int k;
      int hits;
      logic [31:0] d0;

      arst_n        = 1'b0;
      sel_in        = '0;
      sel_valid     = 1'b0;
      mute          = 1'b0;
      m_axis_tready = 1'b1;

      // 1: reset values, then the single INIT beat
      repeat (3) @(negedge aclk);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_at_target", 64'(at_target), 64'd0);
      arst_n = 1'b1;
      wait_idle(50);
      chk("init_beats", 64'(beats.size()), 64'd1);
      if (beats.size() > 0) chk("init_beat_data", 64'(beats[0]), 64'd0);

      // 2: sel=1 ramps up in four beats, four cycles apart
      clear_log();
      strobe(4'd1);
      @(negedge aclk);
      chk("t2_busy", 64'(busy), 64'd1);
      wait_idle(200);
      chk("t2_count", 64'(beats.size()), 64'd4);
      if (beats.size() == 4) begin
         chk("t2_b0", 64'(beats[0]), 64'd214750);
         chk("t2_b1", 64'(beats[1]), 64'd429500);
         chk("t2_b2", 64'(beats[2]), 64'd644250);
         chk("t2_b3", 64'(beats[3]), 64'd859000);
         for (int i = 1; i < 4; i++)
            chk($sformatf("t2_gap%0d", i), 64'(beat_cyc[i] - beat_cyc[i-1]), 64'd4);
      end

      // 3: ramp down to 0; sel=3 mid-ramp is held until the ramp completes
      clear_log();
      strobe(4'd0);
      wait_beats(2, 100);
      strobe(4'd3);
      wait_idle(400);
      model_ramp(REF, 32'd0);
      model_ramp(32'd0, 32'd2577000);
      compare_seq("t3");
      if (beats.size() > 0) chk("t3_last", 64'(beats[beats.size()-1]), 64'd2577000);

      // 4: two strobes in one ramp; only the last code is served
      clear_log();
      strobe(4'd1);
      wait_beats(2, 100);
      strobe(4'd5);
      @(negedge aclk);
      strobe(4'd2);
      wait_idle(400);
      model_ramp(32'd2577000, REF);
      model_ramp(REF, 32'd1718000);
      compare_seq("t4");
      hits = 0;
      foreach (beats[i]) if (beats[i] == 32'd4295000) hits++;
      chk("t4_no_4295000", 64'(hits), 64'd0);

      // 5: backpressure holds the beat and freezes the tick counter
      clear_log();
      strobe(4'd4);
      wait_beats(2, 100);
      m_axis_tready = 1'b0;
      for (int i = 0; i < 20 && !m_axis_tvalid; i++) @(negedge aclk);
      chk("t5_stall_valid", 64'(m_axis_tvalid), 64'd1);
      k  = beats.size();
      d0 = m_axis_tdata;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         chk($sformatf("t5_hold%0d", i), 64'(m_axis_tdata), 64'(d0));
      end
      chk("t5_still_valid", 64'(m_axis_tvalid), 64'd1);
      m_axis_tready = 1'b1;
      wait_idle(400);
      model_ramp(32'd1718000, 32'd3436000);
      compare_seq("t5");
      if (k > 0 && k + 1 < beats.size()) begin
         chk("t5_stalled_gap", 64'(beat_cyc[k] - beat_cyc[k-1] >= 20), 64'd1);
         chk("t5_resume_gap", 64'(beat_cyc[k+1] - beat_cyc[k]), 64'd4);
      end

      // 6: mute down and up at sel=15, then reset mid-ramp
      clear_log();
      strobe(4'd15);
      wait_idle(1000);
      model_ramp(32'd3436000, 32'd12885000);
      compare_seq("t6_up");
      clear_log();
      mute = 1'b1;
      wait_idle(1000);
      model_ramp(32'd12885000, 32'd0);
      compare_seq("t6_mute");
      clear_log();
      mute = 1'b0;
      wait_idle(1000);
      model_ramp(32'd0, 32'd12885000);
      compare_seq("t6_unmute");
      chk("t6_unmute_len", 64'(beats.size()), 64'd60);

      mute = 1'b1;
      wait_beats(3, 100);
      arst_n = 1'b0;
      mute   = 1'b0;
      repeat (3) @(negedge aclk);
      chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_at_target", 64'(at_target), 64'd0);
      clear_log();
      arst_n = 1'b1;
      wait_idle(50);
      chk("t6_post_rst_beats", 64'(beats.size()), 64'd1);
      if (beats.size() > 0) chk("t6_post_rst_data", 64'(beats[0]), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
